// File: rtl/tap_line_sequencer.sv
// tap_line_sequencer: paced sample handshake, tap-line shift strobe and MAC tap stepping.
module tap_line_sequencer #(
  parameter int TOTAL_TAPS    = 9,
  parameter int TAP_SEL_WIDTH = 4,
  parameter int PACE_WIDTH    = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_pace_en,
  input  logic                     i_sample_valid,
  output logic                     o_sample_ready,
  output logic                     o_shift_en,
  output logic                     o_acc_clr,
  output logic                     o_acc_en,
  output logic [TAP_SEL_WIDTH-1:0] o_tap_sel,
  output logic                     o_result_valid,
  input  logic                     i_result_ready,
  output logic                     o_busy,
  output logic                     o_overrun,
  output logic                     o_LED
);
  typedef enum logic [1:0] {IDLE, SHIFT, MAC, HOLD} state_t;
  state_t                   state, state_d;
  logic [TAP_SEL_WIDTH-1:0] tap_sel, tap_sel_d;
  logic [PACE_WIDTH-1:0]    pace_cnt;
  logic                     pace_stb;
  logic                     last_tap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap_sel   <= '0;
      pace_cnt  <= '0;
      pace_stb  <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state    <= state_d;
      tap_sel  <= tap_sel_d;
      pace_cnt <= pace_cnt + PACE_WIDTH'(1);
      pace_stb <= pace_cnt == '0;
      if (pace_stb && i_pace_en && state != IDLE) o_overrun <= 1'b1;
    end
  end
  always_comb begin
    state_d        = state;
    tap_sel_d      = tap_sel;
    last_tap       = tap_sel == TAP_SEL_WIDTH'(TOTAL_TAPS - 1);
    o_sample_ready = state == IDLE && rst_n && (!i_pace_en || pace_stb);
    o_shift_en     = state == SHIFT;
    o_acc_clr      = state == SHIFT;
    o_acc_en       = state == MAC;
    o_tap_sel      = state == MAC ? tap_sel : '0;
    o_result_valid = state == HOLD;
    o_busy         = state != IDLE;
    o_LED          = !pace_cnt[PACE_WIDTH-1];
    case (state)
      IDLE:  state_d = i_sample_valid && o_sample_ready ? SHIFT : IDLE;
      SHIFT: begin
        state_d   = MAC;
        tap_sel_d = '0;
      end
      MAC: begin
        state_d   = last_tap ? HOLD : MAC;
        tap_sel_d = last_tap ? '0 : tap_sel + TAP_SEL_WIDTH'(1);
      end
      HOLD:    state_d = i_result_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_tap_line_sequencer.sv
// tb_tap_line_sequencer: directed checks of handshake timing, pacing, overrun, reset and heartbeat.
module tb_tap_line_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_pace_en = 1'b0;
  logic       i_sample_valid = 1'b0;
  logic       i_result_ready = 1'b0;
  logic       o_sample_ready, o_shift_en, o_acc_clr, o_acc_en, o_result_valid;
  logic       o_busy, o_overrun, o_LED;
  logic [3:0] o_tap_sel;
  logic [6:0] obs;
  int         checks = 0;
  int         errors = 0;
  int         k = 0;
  tap_line_sequencer #(.TOTAL_TAPS(9), .TAP_SEL_WIDTH(4), .PACE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_pace_en(i_pace_en), .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready), .o_shift_en(o_shift_en), .o_acc_clr(o_acc_clr),
    .o_acc_en(o_acc_en), .o_tap_sel(o_tap_sel), .o_result_valid(o_result_valid),
    .i_result_ready(i_result_ready), .o_busy(o_busy), .o_overrun(o_overrun), .o_LED(o_LED)
  );
  always #5 clk = ~clk;
  assign obs = {o_sample_ready, o_shift_en, o_acc_clr, o_acc_en, o_result_valid, o_busy, o_overrun};
  // Advances one clock, leaving the bench at a falling edge; k tracks pace_cnt since release.
  task automatic tick();
    @(negedge clk);
    k++;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    i_sample_valid = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (obs !== 7'b0 || o_tap_sel !== 4'd0 || o_LED !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: obs=%b tap=%0d led=%b, expected obs=0000000 tap=0 led=1", obs, o_tap_sel, o_LED);
    end
    i_sample_valid = 1'b0;
    rst_n = 1'b1;
    k = 0;
  endtask
  task automatic test_heartbeat();
    i_pace_en = 1'b1;
    #1;
    for (int j = 0; j <= 32; j++) begin
      if (j > 0) begin
        tick();
        #1;
      end
      checks++;
      if (o_LED !== ((k % 16) < 8) || o_sample_ready !== ((k % 16) == 1) || o_overrun !== 1'b0) begin
        errors++;
        $display("FAIL heartbeat k=%0d: led=%b ready=%b ovr=%b, expected led=%b ready=%b ovr=0",
                 k, o_LED, o_sample_ready, o_overrun, (k % 16) < 8, (k % 16) == 1);
      end
    end
  endtask
  task automatic test_free_run();
    i_pace_en = 1'b0;
    i_sample_valid = 1'b1;
    i_result_ready = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++;
      $display("FAIL fr_accept: obs=%b expected 1000000", obs);
    end
    tick();
    i_sample_valid = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0110010 || o_tap_sel !== 4'd0) begin
      errors++;
      $display("FAIL fr_shift: obs=%b tap=%0d expected obs=0110010 tap=0", obs, o_tap_sel);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      #1;
      checks++;
      if (obs !== 7'b0001010 || o_tap_sel !== 4'(i)) begin
        errors++;
        $display("FAIL fr_mac%0d: obs=%b tap=%0d expected obs=0001010 tap=%0d", i, obs, o_tap_sel, i);
      end
    end
    tick();
    i_sample_valid = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0000110 || o_tap_sel !== 4'd0) begin
      errors++;
      $display("FAIL fr_hold: obs=%b tap=%0d expected obs=0000110 tap=0", obs, o_tap_sel);
    end
    tick();
    i_sample_valid = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++;
      $display("FAIL fr_reaccept: obs=%b expected 1000000", obs);
    end
  endtask
  task automatic test_back_to_back();
    i_sample_valid = 1'b1;
    i_result_ready = 1'b1;
    for (int j = 1; j <= 36; j++) begin
      tick();
      #1;
      checks++;
      if (o_shift_en !== ((j % 12) == 1) || o_result_valid !== ((j % 12) == 11)) begin
        errors++;
        $display("FAIL b2b j=%0d: shift=%b rv=%b expected shift=%b rv=%b",
                 j, o_shift_en, o_result_valid, (j % 12) == 1, (j % 12) == 11);
      end
    end
    i_sample_valid = 1'b0;
    tick();
  endtask
  task automatic test_backpressure();
    i_sample_valid = 1'b1;
    i_result_ready = 1'b0;
    for (int j = 0; j < 11; j++) tick();
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) tick();
      #1;
      checks++;
      if (o_result_valid !== 1'b1 || o_sample_ready !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b ready=%b busy=%b expected rv=1 ready=0 busy=1",
                 j, o_result_valid, o_sample_ready, o_busy);
      end
    end
    i_result_ready = 1'b1;
    tick();
    i_sample_valid = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b1000000) begin
      errors++;
      $display("FAIL bp_release: obs=%b expected 1000000", obs);
    end
  endtask
  task automatic test_paced();
    int accepts = 0;
    i_pace_en = 1'b1;
    i_sample_valid = 1'b1;
    i_result_ready = 1'b1;
    for (int j = 1; j <= 48; j++) begin
      tick();
      #1;
      if (o_sample_ready) accepts++;
      checks++;
      if (o_sample_ready !== ((k % 16) == 1) || o_shift_en !== ((k % 16) == 2) || o_overrun !== 1'b0) begin
        errors++;
        $display("FAIL paced k=%0d: ready=%b shift=%b ovr=%b expected ready=%b shift=%b ovr=0",
                 k, o_sample_ready, o_shift_en, o_overrun, (k % 16) == 1, (k % 16) == 2);
      end
    end
    checks++;
    if (accepts !== 3) begin
      errors++;
      $display("FAIL paced_count: accepts=%0d expected 3", accepts);
    end
    i_sample_valid = 1'b0;
    for (int j = 0; j < 16; j++) tick();
  endtask
  task automatic test_overrun();
    i_pace_en = 1'b1;
    i_sample_valid = 1'b1;
    i_result_ready = 1'b0;
    for (int j = 0; j < 16 && (k % 16) != 1; j++) tick();
    #1;
    checks++;
    if (o_sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovr_accept: ready=%b expected 1", o_sample_ready);
    end
    for (int j = 1; j <= 17; j++) begin
      tick();
      i_sample_valid = 1'b0;
      #1;
      checks++;
      if (o_overrun !== (j >= 17)) begin
        errors++;
        $display("FAIL ovr_step%0d: ovr=%b expected %b", j, o_overrun, j >= 17);
      end
    end
    i_result_ready = 1'b1;
    tick();
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_overrun !== 1'b1 || o_result_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_sticky: busy=%b ovr=%b rv=%b expected busy=0 ovr=1 rv=0", o_busy, o_overrun, o_result_valid);
    end
  endtask
  task automatic test_reset_mid_mac();
    i_pace_en = 1'b0;
    i_sample_valid = 1'b1;
    i_result_ready = 1'b1;
    for (int j = 0; j < 6; j++) tick();
    #1;
    checks++;
    if (o_acc_en !== 1'b1 || o_tap_sel !== 4'd4) begin
      errors++;
      $display("FAIL rm_pre: acc=%b tap=%0d expected acc=1 tap=4", o_acc_en, o_tap_sel);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 7'b0 || o_tap_sel !== 4'd0 || o_LED !== 1'b1) begin
      errors++;
      $display("FAIL rm_async: obs=%b tap=%0d led=%b expected obs=0000000 tap=0 led=1", obs, o_tap_sel, o_LED);
    end
    tick();
    tick();
    rst_n = 1'b1;
    k = 0;
    #1;
    checks++;
    if (o_sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_ready: ready=%b expected 1", o_sample_ready);
    end
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (j == 1) i_sample_valid = 1'b0;
      #1;
      checks++;
      if (o_result_valid !== (j == 11) || o_shift_en !== (j == 1)) begin
        errors++;
        $display("FAIL rm_after j=%0d: rv=%b shift=%b expected rv=%b shift=%b",
                 j, o_result_valid, o_shift_en, j == 11, j == 1);
      end
    end
  endtask
  initial begin
    test_reset();
    test_heartbeat();
    test_free_run();
    test_back_to_back();
    test_backpressure();
    test_paced();
    test_overrun();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tap_line_sequencer.md
# tap_line_sequencer

Control block for the wavelet filter's tap shift line and its multiply-accumulate stage. It accepts input samples over a valid/ready handshake, optionally paced by a free-running rate strobe. For each accepted sample it issues one shift enable to the tap line, then steps a tap index across all taps while enabling the accumulator, and holds a result-valid until the downstream consumer takes it. It also flags lost pacing slots and drives the heartbeat LED.

## Interface
- `TOTAL_TAPS`, default 9: number of taps in the line; MAC steps per sample.
- `TAP_SEL_WIDTH`, default 4: width of the tap index; must satisfy 2^TAP_SEL_WIDTH ≥ TOTAL_TAPS.
- `PACE_WIDTH`, default 25: width of the free-running pacing counter.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `i_pace_en`  in  1: 1 = accept samples only on pace strobe cycles; 0 = accept whenever idle.
- `i_sample_valid`  in  1: upstream sample available.
- `o_sample_ready`  out  1: sequencer can take a sample this cycle.
- `o_shift_en`  out  1: one-cycle shift strobe to the tap line.
- `o_acc_clr`  out  1: clear the accumulator.
- `o_acc_en`  out  1: accumulate product of tap `o_tap_sel`.
- `o_tap_sel`  out  TAP_SEL_WIDTH: tap index for the MAC.
- `o_result_valid`  out  1: accumulator holds a finished result.
- `i_result_ready`  in  1: downstream takes the result.
- `o_busy`  out  1: state ≠ IDLE.
- `o_overrun`  out  1: sticky; a pacing slot was missed while busy.
- `o_LED`  out  1: heartbeat, equal to `!pace_cnt[PACE_WIDTH-1]`.

## Operation
- Pacing: `pace_cnt` increments every cycle and wraps at 2^PACE_WIDTH. `pace_stb` is a register set to 1 for exactly the one cycle after the cycle in which `pace_cnt`==0.
- States: IDLE, SHIFT, MAC, HOLD. State, `tap_sel` and `o_overrun` are registered. All other outputs are decoded from them.
- IDLE:
  - `o_sample_ready` = `rst_n & (!i_pace_en | pace_stb)`.
  - When `i_sample_valid & o_sample_ready`, go to SHIFT. Otherwise stay in IDLE.
- SHIFT: one cycle. `o_shift_en`=1 and `o_acc_clr`=1. Next state is MAC with `tap_sel`=0.
- MAC: `o_acc_en`=1. `tap_sel` increments each cycle. When `tap_sel`==TOTAL_TAPS-1, go to HOLD.
- HOLD:
  - `o_result_valid`=1, held stable until `i_result_ready`=1.
  - In the cycle `i_result_ready`=1, the next state is IDLE.
  - No new sample is accepted in HOLD.
- `o_tap_sel`=0 in every state except MAC. `o_shift_en`, `o_acc_clr`, `o_acc_en` and `o_result_valid` are 0 outside the states listed above.
- Overrun: if `pace_stb`=1 and `i_pace_en`=1 while the state ≠ IDLE, set `o_overrun`. It stays set until reset.
  - A pace strobe in IDLE with `i_sample_valid`=0 is not an overrun.
- `i_pace_en` may change at any time. It only affects `o_sample_ready` and the overrun check in the same cycle.
- Reset (asynchronous assert, any state, including mid-MAC):
  - state=IDLE, `tap_sel`=0, `pace_cnt`=0, `pace_stb`=0, `o_overrun`=0.
  - All outputs 0, except `o_LED`=1.
  - A partially accumulated result is abandoned. No result-valid is raised.

## Timing
- Handshake accepted at cycle T:
  - `o_shift_en` at T+1.
  - `o_acc_en` at T+2..T+1+TOTAL_TAPS, with `o_tap_sel` = 0..TOTAL_TAPS-1.
  - `o_result_valid` from T+2+TOTAL_TAPS.
- Minimum sample period, with the result taken immediately: TOTAL_TAPS+3 cycles (12 at default).
- `o_shift_en` is asserted exactly once per accepted sample, never in any other cycle.
- With pacing enabled, at most one sample is accepted per 2^PACE_WIDTH cycles.
- `o_sample_ready` is combinational on `pace_stb`, `i_pace_en`, state and `rst_n`. There is no combinational path from `i_sample_valid` to `o_sample_ready`.
- Release of `rst_n` is synchronised externally. The first state update occurs on the first rising edge with `rst_n`=1.

## Test plan
1. Free-run (`i_pace_en`=0):
   - Stimulus: `i_sample_valid`=1 and `i_result_ready`=1 held, handshake at cycle 5.
   - Required: `o_shift_en` at cycle 6; `o_acc_en` at cycles 7..15 with `o_tap_sel` 0..8; `o_result_valid` at cycle 16; next accept at cycle 17.
2. Back-pressure:
   - Stimulus: `i_result_ready`=0 for 20 cycles after `o_result_valid` rises.
   - Required: `o_result_valid` stays 1 and `o_sample_ready` stays 0 throughout; return to IDLE the cycle after `i_result_ready`=1.
3. Paced mode (PACE_WIDTH=4, `i_pace_en`=1, valid held):
   - Required: exactly one accept per 16 cycles, each in a cycle with `pace_stb`=1; `o_overrun` remains 0.
4. Overrun (PACE_WIDTH=4):
   - Stimulus: hold `i_result_ready`=0 across a pace strobe.
   - Required: `o_overrun`=1 from the next cycle; it stays 1 after the result is taken.
5. Reset mid-MAC:
   - Stimulus: drive `rst_n` low at `tap_sel`=4.
   - Required: immediately `o_acc_en`=0, `o_tap_sel`=0, `o_busy`=0, `o_LED`=1; after release, a new sample is accepted with no stale `o_result_valid`.
6. Heartbeat (PACE_WIDTH=4):
   - Required: `o_LED`=1 for 8 cycles, then 0 for 8 cycles, repeating from reset release.
